resp_demux_2: RTL and testbench

- Inverse of the two-way fixed-priority request arbiter: takes one decoupled stream of 32-bit responses, each tagged with a 1-bit destination id.
- Steers each beat to one of two independently back-pressured output ports.
- Each output has its own small FIFO, so a stalled consumer never blocks traffic to the other.
- Sits on the response return path between the shared memory/bus side and the two requesters.

---
 rtl/resp_demux_2.sv | 83 ++++++++
 tb/tb_resp_demux_2.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/resp_demux_2.sv
// rtl/resp_demux_2.sv - steers tagged response beats into two independently back-pressured FIFOs
module resp_demux_2 #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     io_in_ready,
    input  logic                     io_in_valid,
    input  logic [DATA_W-1:0]        io_in_bits_data,
    input  logic                     io_in_bits_id,
    input  logic                     io_out_0_ready,
    output logic                     io_out_0_valid,
    output logic [DATA_W-1:0]        io_out_0_bits_data,
    output logic [$clog2(DEPTH):0]   io_out_0_count,
    input  logic                     io_out_1_ready,
    output logic                     io_out_1_valid,
    output logic [DATA_W-1:0]        io_out_1_bits_data,
    output logic [$clog2(DEPTH):0]   io_out_1_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [2][DEPTH];
    logic [AW-1:0]     wptr_q [2];
    logic [AW-1:0]     wptr_d [2];
    logic [AW-1:0]     rptr_q [2];
    logic [AW-1:0]     rptr_d [2];
    logic [CW-1:0]     cnt_q  [2];
    logic [CW-1:0]     cnt_d  [2];
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        out_ready;

    assign out_ready   = {io_out_1_ready, io_out_0_ready};
    // Full FIFO refuses input even while it is being popped: no pass-through path.
    assign io_in_ready = (cnt_q[io_in_bits_id] != CW'(DEPTH));

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            push[n]   = io_in_valid && io_in_ready && (io_in_bits_id == 1'(n));
            pop[n]    = (cnt_q[n] != '0) && out_ready[n];
            wptr_d[n] = wptr_q[n] + AW'(push[n]);
            rptr_d[n] = rptr_q[n] + AW'(pop[n]);
            cnt_d[n]  = cnt_q[n];
            if (push[n] && !pop[n]) begin
                cnt_d[n] = cnt_q[n] + CW'(1);
            end else if (pop[n] && !push[n]) begin
                cnt_d[n] = cnt_q[n] - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int n = 0; n < 2; n++) begin
            if (reset) begin
                cnt_q[n]  <= '0;
                wptr_q[n] <= '0;
                rptr_q[n] <= '0;
            end else begin
                cnt_q[n]  <= cnt_d[n];
                wptr_q[n] <= wptr_d[n];
                rptr_q[n] <= rptr_d[n];
            end
        end
    end

    // Storage is deliberately left out of reset; empty FIFOs mask it to zero below.
    always_ff @(posedge clock) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n]) begin
                mem_q[n][wptr_q[n]] <= io_in_bits_data;
            end
        end
    end

    assign io_out_0_valid     = (cnt_q[0] != '0);
    assign io_out_1_valid     = (cnt_q[1] != '0);
    assign io_out_0_bits_data = io_out_0_valid ? mem_q[0][rptr_q[0]] : '0;
    assign io_out_1_bits_data = io_out_1_valid ? mem_q[1][rptr_q[1]] : '0;
    assign io_out_0_count     = cnt_q[0];
    assign io_out_1_count     = cnt_q[1];
endmodule

// File: tb/tb_resp_demux_2.sv
// tb/tb_resp_demux_2.sv - directed self-checking bench for resp_demux_2
module tb_resp_demux_2;
    logic        clock = 1'b0;
    logic        reset;
    logic        io_in_ready;
    logic        io_in_valid;
    logic [31:0] io_in_bits_data;
    logic        io_in_bits_id;
    logic        io_out_0_ready;
    logic        io_out_0_valid;
    logic [31:0] io_out_0_bits_data;
    logic [1:0]  io_out_0_count;
    logic        io_out_1_ready;
    logic        io_out_1_valid;
    logic [31:0] io_out_1_bits_data;
    logic [1:0]  io_out_1_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    resp_demux_2 #(.DATA_W(32), .DEPTH(2)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_in_ready        (io_in_ready),
        .io_in_valid        (io_in_valid),
        .io_in_bits_data    (io_in_bits_data),
        .io_in_bits_id      (io_in_bits_id),
        .io_out_0_ready     (io_out_0_ready),
        .io_out_0_valid     (io_out_0_valid),
        .io_out_0_bits_data (io_out_0_bits_data),
        .io_out_0_count     (io_out_0_count),
        .io_out_1_ready     (io_out_1_ready),
        .io_out_1_valid     (io_out_1_valid),
        .io_out_1_bits_data (io_out_1_bits_data),
        .io_out_1_count     (io_out_1_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs settled: scores the handshakes of the coming posedge.
    task automatic tick();
        logic [31:0] exp;
        if (io_out_0_valid && io_out_0_ready) begin
            exp = (q0.size() != 0) ? q0.pop_front() : 32'hDEAD_DEAD;
            check("out0_data", io_out_0_bits_data, exp);
        end
        if (io_out_1_valid && io_out_1_ready) begin
            exp = (q1.size() != 0) ? q1.pop_front() : 32'hDEAD_DEAD;
            check("out1_data", io_out_1_bits_data, exp);
        end
        if (io_in_valid && io_in_ready) begin
            if (io_in_bits_id) q1.push_back(io_in_bits_data);
            else               q0.push_back(io_in_bits_data);
        end
        @(negedge clock);
    endtask

    initial begin
        bit acc;
        int guard;
        reset = 1'b1;
        io_in_valid = 1'b0; io_in_bits_data = '0; io_in_bits_id = 1'b0;
        io_out_0_ready = 1'b0; io_out_1_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_in_ready", io_in_ready, 1);
        check("rst_v0", io_out_0_valid, 0);
        check("rst_v1", io_out_1_valid, 0);
        check("rst_d0", io_out_0_bits_data, 0);
        check("rst_d1", io_out_1_bits_data, 0);
        check("rst_c0", io_out_0_count, 0);
        check("rst_c1", io_out_1_count, 0);

        // single beat to out_0
        io_in_valid = 1'b1; io_in_bits_id = 1'b0; io_in_bits_data = 32'hA000_0001;
        io_out_0_ready = 1'b1;
        tick();
        io_in_valid = 1'b0;
        check("p1_v0", io_out_0_valid, 1);
        check("p1_c0", io_out_0_count, 1);
        check("p1_d0", io_out_0_bits_data, 32'hA000_0001);
        check("p1_v1", io_out_1_valid, 0);
        tick();
        check("p1_c0_after", io_out_0_count, 0);
        check("p1_v0_after", io_out_0_valid, 0);

        // fill FIFO 1, independence of FIFO 0
        io_out_0_ready = 1'b0; io_out_1_ready = 1'b0;
        io_in_valid = 1'b1; io_in_bits_id = 1'b1; io_in_bits_data = 32'h11;
        tick();
        io_in_bits_data = 32'h22;
        tick();
        io_in_bits_data = 32'h99;
        check("full_c1", io_out_1_count, 2);
        check("full_in_ready_id1", io_in_ready, 0);
        io_in_bits_id = 1'b0; io_in_bits_data = 32'h33;
        check("full_in_ready_id0", io_in_ready, 1);
        tick();
        io_in_valid = 1'b0;
        check("indep_c0", io_out_0_count, 1);
        check("indep_d0", io_out_0_bits_data, 32'h33);
        check("indep_c1", io_out_1_count, 2);

        // no pass-through while full and popping
        io_out_1_ready = 1'b1;
        io_in_valid = 1'b1; io_in_bits_id = 1'b1; io_in_bits_data = 32'h44;
        check("no_passthru", io_in_ready, 0);
        tick();
        check("retry_ready", io_in_ready, 1);
        check("retry_c1", io_out_1_count, 1);
        tick();
        io_in_valid = 1'b0;
        check("pushpop_c1", io_out_1_count, 1);
        check("pushpop_d1", io_out_1_bits_data, 32'h44);
        tick();
        check("drain_c1", io_out_1_count, 0);
        io_out_0_ready = 1'b1;
        tick();
        check("drain_c0", io_out_0_count, 0);

        // alternating stream, random back-pressure
        for (int i = 0; i < 8; i++) begin
            io_in_valid = 1'b1; io_in_bits_id = 1'(i % 2); io_in_bits_data = 32'hB000_0000 + 32'(i);
            guard = 0;
            do begin
                io_out_0_ready = 1'($urandom_range(0, 1));
                io_out_1_ready = 1'($urandom_range(0, 1));
                acc = io_in_ready;
                tick();
                guard++;
            end while (!acc && guard < 50);
            if (!acc) check("stream_accept_timeout", guard, 0);
        end
        io_in_valid = 1'b0; io_out_0_ready = 1'b1; io_out_1_ready = 1'b1;
        repeat (4) tick();
        check("stream_q0_left", q0.size(), 0);
        check("stream_q1_left", q1.size(), 0);
        check("stream_c0", io_out_0_count, 0);
        check("stream_c1", io_out_1_count, 0);

        // reset mid-transfer with offset pointers
        io_out_0_ready = 1'b0;
        io_in_valid = 1'b1; io_in_bits_id = 1'b0; io_in_bits_data = 32'hC1;
        tick();
        io_out_0_ready = 1'b1; io_in_bits_data = 32'hC2;
        tick();
        io_out_0_ready = 1'b0; io_in_bits_data = 32'hC3;
        tick();
        io_in_valid = 1'b0;
        check("pre_rst_c0", io_out_0_count, 2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        q0.delete(); q1.delete();
        check("mid_rst_v0", io_out_0_valid, 0);
        check("mid_rst_c0", io_out_0_count, 0);
        check("mid_rst_in_ready", io_in_ready, 1);
        io_in_valid = 1'b1; io_in_bits_data = 32'hD1;
        tick();
        io_in_valid = 1'b0;
        check("post_rst_d0", io_out_0_bits_data, 32'hD1);
        check("post_rst_c0", io_out_0_count, 1);
        io_out_0_ready = 1'b1;
        tick();
        check("post_rst_drain", io_out_0_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
